// File: rtl/cache_nway_wb_if.sv
// cache_nway_wb_if
//   Bundles the processor-side and memory-side handshake of cache_nway_wb.
//   modport slave  : the cache itself
//   modport master : the environment (core + block memory) driving the cache
// Signals
//   proc_read/proc_write/proc_addr/proc_wdata : core request, held while proc_stall=1
//   proc_rdata/proc_stall                     : read data and stall back to the core
//   mem_read/mem_write/mem_addr/mem_wdata     : line request to memory, held until mem_ready
//   mem_rdata/mem_ready                       : refill line and one-cycle completion pulse
interface cache_nway_wb_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4
);
  localparam int OFF_W   = $clog2(WORDS);
  localparam int MADDR_W = ADDR_W - OFF_W;
  localparam int LINE_W  = WORDS * DATA_W;

  logic               proc_read;
  logic               proc_write;
  logic [ADDR_W-1:0]  proc_addr;
  logic [DATA_W-1:0]  proc_wdata;
  logic [DATA_W-1:0]  proc_rdata;
  logic               proc_stall;
  logic               mem_read;
  logic               mem_write;
  logic [MADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_wdata;
  logic [LINE_W-1:0]  mem_rdata;
  logic               mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_nway_wb.sv
// cache_nway_wb
//   N-way set-associative write-back, write-allocate data cache with true-LRU
//   replacement. Hits complete in the request cycle; a miss stalls the core while
//   the FSM writes back a dirty victim and refills the line from memory.
// Ports
//   clk           clock, all state on rising edge
//   proc_reset_n  asynchronous active-low reset; all outputs forced to 0 while low
//   bus           cache_nway_wb_if.slave (processor and memory handshake)
//   stats_clr, hit_cnt, miss_cnt  only present when CACHE_STATS_EN is defined
// Configuration macro
//   CACHE_STATS_EN : adds saturating hit/miss counters with synchronous clear
module cache_nway_wb #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input logic clk,
  input logic proc_reset_n,
  cache_nway_wb_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int MADDR_W = ADDR_W - OFF_W;
  localparam int LINE_W  = WORDS * DATA_W;
  localparam int AGE_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE} state_t;

  state_t            state;
  logic [AGE_W-1:0]  victim_q;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [TAG_W-1:0]  tag_in;
  logic              req;
  logic              hit;
  logic [AGE_W-1:0]  hit_way;
  logic [AGE_W-1:0]  victim_way;
  logic              idle_hit;
  logic              idle_miss;

  assign idx       = bus.proc_addr[OFF_W +: IDX_W];
  assign off       = bus.proc_addr[OFF_W-1:0];
  assign tag_in    = bus.proc_addr[ADDR_W-1 -: TAG_W];
  assign req       = bus.proc_read | bus.proc_write;
  assign idle_hit  = (state == IDLE) && req && hit;
  assign idle_miss = (state == IDLE) && req && !hit;

  // Tag lookup and victim choice. The invalid scan runs high-to-low so the
  // lowest-index invalid way wins; only when every way is valid does the
  // oldest (age WAYS-1) way get picked.
  always_comb begin
    logic found_invalid;
    hit           = 1'b0;
    hit_way       = '0;
    victim_way    = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[idx][w] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        found_invalid = 1'b1;
        victim_way    = AGE_W'(w);
      end
    end
  end

  // Outputs decode straight from state so a hit answers in its own cycle; an
  // asserted reset silences everything, including an in-flight memory request.
  always_comb begin
    bus.proc_rdata = '0;
    bus.proc_stall = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (proc_reset_n) begin
      unique case (state)
        IDLE: begin
          bus.proc_stall = idle_miss;
          if (bus.proc_read && !bus.proc_write && hit)
            bus.proc_rdata = data_q[idx][hit_way][off*DATA_W +: DATA_W];
        end
        WRITE_BACK: begin
          bus.proc_stall = 1'b1;
          bus.mem_write  = 1'b1;
          bus.mem_addr   = {tag_q[idx][victim_q], idx};
          bus.mem_wdata  = data_q[idx][victim_q];
        end
        ALLOCATE: begin
          bus.proc_stall = 1'b1;
          bus.mem_read   = 1'b1;
          bus.mem_addr   = bus.proc_addr[ADDR_W-1:OFF_W];
        end
        default: ;
      endcase
    end
  end

  // Control state: FSM, valid/dirty/tag bits and LRU ages. On a hit the touched
  // way becomes MRU and every way younger than it ages by one, which keeps the
  // ages of a set a permutation. A refill leaves the ages alone because the held
  // request replays as a hit on the next cycle and does the promotion then.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state    <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (idle_hit) begin
            if (bus.proc_write) dirty_q[idx][hit_way] <= 1'b1;
            for (int w = 0; w < WAYS; w++) begin
              if (AGE_W'(w) == hit_way)
                age_q[idx][w] <= '0;
              else if (age_q[idx][w] < age_q[idx][hit_way])
                age_q[idx][w] <= age_q[idx][w] + 1'b1;
            end
          end else if (idle_miss) begin
            victim_q <= victim_way;
            state    <= (valid_q[idx][victim_way] && dirty_q[idx][victim_way])
                        ? WRITE_BACK : ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (bus.mem_ready) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            tag_q[idx][victim_q]   <= tag_in;
            state                  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset: contents behind a cleared valid bit are never
  // observed.
  always_ff @(posedge clk) begin
    if (idle_hit && bus.proc_write)
      data_q[idx][hit_way][off*DATA_W +: DATA_W] <= bus.proc_wdata;
    else if ((state == ALLOCATE) && bus.mem_ready)
      data_q[idx][victim_q] <= bus.mem_rdata;
  end

`ifdef CACHE_STATS_EN
  logic replay_q;

  // Saturating counters. replay_q marks the cycle right after a refill so the
  // replayed access of a miss is not also counted as a hit.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      replay_q <= 1'b0;
    end else begin
      replay_q <= (state == ALLOCATE) && bus.mem_ready;
      if (stats_clr) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end else begin
        if (idle_hit && !replay_q && (hit_cnt != 32'hFFFF_FFFF))
          hit_cnt <= hit_cnt + 32'd1;
        if (idle_miss && (miss_cnt != 32'hFFFF_FFFF))
          miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_nway_wb.sv
// tb_cache_nway_wb
//   Self-checking bench for cache_nway_wb with default geometry (2 ways, 4 sets,
//   4 words). A directed vector table covers fill, hit, LRU eviction and dirty
//   write-back; hand sequences cover reset and reset during a refill; a random
//   phase is scored against a recency-list model of the cache and a backing
//   memory array.
module tb_cache_nway_wb;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int WORDS   = 4;
  localparam int SETS    = 4;
  localparam int WAYS    = 2;
  localparam int OFF_W   = 2;
  localparam int IDX_W   = 2;
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int MADDR_W = ADDR_W - OFF_W;
  localparam int LINE_W  = WORDS * DATA_W;

  logic clk = 1'b0;
  logic proc_reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_nway_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();

`ifdef CACHE_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  cache_nway_wb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk),
    .proc_reset_n(proc_reset_n),
    .bus(bus)
`ifdef CACHE_STATS_EN
    ,
    .stats_clr(stats_clr),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check_output(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: each set is a list of resident lines, most recent first.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    bit                dirty;
    logic [LINE_W-1:0] data;
  } mline_t;

  mline_t set_q [SETS][$];
  logic [LINE_W-1:0] mem_m [logic [MADDR_W-1:0]];

  function automatic logic [LINE_W-1:0] mem_line(input logic [MADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    if (mem_m.exists(a)) return mem_m[a];
    for (int i = 0; i < WORDS; i++) l[i*DATA_W +: DATA_W] = {a[23:0], 8'(i)};
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) set_q[s].delete();
  endtask

  // One memory phase of a miss. Holds mem_ready low for lat cycles, then pulses
  // it, checking the request on every cycle the cache should be presenting it.
  task automatic mem_phase(input bit is_wr, input logic [MADDR_W-1:0] a,
                           input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rl,
                           input int lat);
    for (int k = 0; k <= lat; k++) begin
      if (k == lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rl;
      end
      @(negedge clk);
      check_output("phase_stall", LINE_W'(bus.proc_stall), LINE_W'(1));
      check_output(is_wr ? "wb_mem_write" : "al_mem_read",
                   LINE_W'(is_wr ? bus.mem_write : bus.mem_read), LINE_W'(1));
      check_output(is_wr ? "wb_no_mem_read" : "al_no_mem_write",
                   LINE_W'(is_wr ? bus.mem_read : bus.mem_write), LINE_W'(0));
      check_output(is_wr ? "wb_mem_addr" : "al_mem_addr", LINE_W'(bus.mem_addr), LINE_W'(a));
      if (is_wr) check_output("wb_mem_wdata", bus.mem_wdata, wd);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // Runs one complete processor access, checking every cycle against the model,
  // and reports what the DUT did for table-level comparison.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int lat,
                                output logic obs_miss, output logic obs_wb,
                                output logic [MADDR_W-1:0] obs_wb_addr,
                                output logic [DATA_W-1:0] obs_rdata);
    int s, pos;
    logic [TAG_W-1:0] t;
    logic [OFF_W-1:0] o;
    logic [MADDR_W-1:0] line;
    logic [DATA_W-1:0] exp_rd;
    mline_t ent, vic;
    bit m_hit, m_wb;
    s    = int'(addr[OFF_W +: IDX_W]);
    t    = addr[ADDR_W-1 -: TAG_W];
    o    = addr[OFF_W-1:0];
    line = addr[ADDR_W-1:OFF_W];
    pos  = -1;
    for (int i = 0; i < set_q[s].size(); i++) if (set_q[s][i].tag == t) pos = i;
    m_hit = (pos >= 0);
    m_wb  = 1'b0;
    obs_wb = 1'b0;
    obs_wb_addr = '0;
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wdata;
    @(negedge clk);
    obs_miss = bus.proc_stall;
    check_output("first_stall", LINE_W'(bus.proc_stall), LINE_W'(!m_hit));
    check_output("first_no_mem", LINE_W'({bus.mem_read, bus.mem_write}), LINE_W'(0));
    if (m_hit) begin
      ent = set_q[s][pos];
      set_q[s].delete(pos);
    end else begin
      @(posedge clk); #1;
      obs_wb = bus.mem_write;
      obs_wb_addr = bus.mem_addr;
      if (set_q[s].size() == WAYS) begin
        vic = set_q[s].pop_back();
        m_wb = vic.dirty;
        if (m_wb) begin
          mem_phase(1'b1, {vic.tag, IDX_W'(s)}, vic.data, '0, lat);
          mem_m[{vic.tag, IDX_W'(s)}] = vic.data;
        end
      end
      mem_phase(1'b0, line, '0, mem_line(line), lat);
      ent.tag = t;
      ent.dirty = 1'b0;
      ent.data = mem_line(line);
      @(negedge clk);
      check_output("replay_stall", LINE_W'(bus.proc_stall), LINE_W'(0));
    end
    exp_rd = (rd && !wr) ? ent.data[o*DATA_W +: DATA_W] : '0;
    obs_rdata = bus.proc_rdata;
    check_output("rdata", LINE_W'(bus.proc_rdata), LINE_W'(exp_rd));
    if (wr) begin
      ent.data[o*DATA_W +: DATA_W] = wdata;
      ent.dirty = 1'b1;
    end
    set_q[s].push_front(ent);
    @(posedge clk); #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = ADDR_W'($urandom);
    @(negedge clk);
    check_output("idle_stall", LINE_W'(bus.proc_stall), LINE_W'(0));
    check_output("idle_rdata", LINE_W'(bus.proc_rdata), LINE_W'(0));
    check_output("idle_mem", LINE_W'({bus.mem_read, bus.mem_write}), LINE_W'(0));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic               rd;
    logic               wr;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    int                 lat;
    logic               exp_miss;
    logic               exp_wb;
    logic [MADDR_W-1:0] exp_wb_addr;
    logic [DATA_W-1:0]  exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic om, ow;
    logic [MADDR_W-1:0] owa;
    logic [DATA_W-1:0] ord;

    vecs[0] = '{1, 0, 30'h10, 32'h0,        0, 1, 0, 28'h0, 32'h0};
    vecs[1] = '{0, 1, 30'h11, 32'hDEADBEEF, 0, 0, 0, 28'h0, 32'h0};
    vecs[2] = '{1, 0, 30'h11, 32'h0,        0, 0, 0, 28'h0, 32'hDEADBEEF};
    vecs[3] = '{1, 0, 30'h20, 32'h0,        1, 1, 0, 28'h0, 32'h800};
    vecs[4] = '{1, 0, 30'h10, 32'h0,        0, 0, 0, 28'h0, 32'h0};
    vecs[5] = '{1, 0, 30'h30, 32'h0,        2, 1, 0, 28'h0, 32'hC00};
    vecs[6] = '{1, 0, 30'h10, 32'h0,        0, 0, 0, 28'h0, 32'h0};
    vecs[7] = '{1, 0, 30'h41, 32'h0,        0, 1, 0, 28'h0, 32'h1001};
    vecs[8] = '{1, 0, 30'h52, 32'h0,        5, 1, 1, 28'h4, 32'h1402};

    mem_m[28'h4] = {32'd3, 32'd2, 32'd1, 32'd0};
    model_reset();

    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;

    // Reset state: everything quiet even with a request presented.
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_stall", LINE_W'(bus.proc_stall), LINE_W'(0));
    check_output("reset_mem", LINE_W'({bus.mem_read, bus.mem_write}), LINE_W'(0));
    check_output("reset_rdata", LINE_W'(bus.proc_rdata), LINE_W'(0));
    bus.proc_read = 1'b0;
    @(posedge clk); #1;
    proc_reset_n = 1'b1;
    idle_cycle();

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                     om, ow, owa, ord);
      check_output($sformatf("vec%0d_miss", i), LINE_W'(om), LINE_W'(vecs[i].exp_miss));
      check_output($sformatf("vec%0d_wb", i), LINE_W'(ow), LINE_W'(vecs[i].exp_wb));
      if (vecs[i].exp_wb)
        check_output($sformatf("vec%0d_wb_addr", i), LINE_W'(owa), LINE_W'(vecs[i].exp_wb_addr));
      check_output($sformatf("vec%0d_rdata", i), LINE_W'(ord), LINE_W'(vecs[i].exp_rdata));
`ifdef CACHE_STATS_EN
      if (i == 2) begin
        check_output("stats_miss", LINE_W'(miss_cnt), LINE_W'(1));
        check_output("stats_hit", LINE_W'(hit_cnt), LINE_W'(2));
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        check_output("stats_miss_clr", LINE_W'(miss_cnt), LINE_W'(0));
        check_output("stats_hit_clr", LINE_W'(hit_cnt), LINE_W'(0));
      end
`endif
    end

    // Reset while refilling: the request must drop at once and all lines vanish.
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h10;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("pre_reset_mem_read", LINE_W'(bus.mem_read), LINE_W'(1));
    #2 proc_reset_n = 1'b0;
    #1;
    check_output("midreset_mem_read", LINE_W'(bus.mem_read), LINE_W'(0));
    check_output("midreset_stall", LINE_W'(bus.proc_stall), LINE_W'(0));
    bus.proc_read = 1'b0;
    @(posedge clk); #1;
    proc_reset_n = 1'b1;
    model_reset();
    apply_stimulus(1'b1, 1'b0, 30'h10, 32'h0, 1, om, ow, owa, ord);
    check_output("post_reset_miss", LINE_W'(om), LINE_W'(1));
    check_output("post_reset_rdata", LINE_W'(ord), LINE_W'(0));

    // Random traffic over a few tags per set so hits, evictions and write-backs mix.
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [ADDR_W-1:0] a;
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle();
      end else begin
        kind = $urandom_range(0, 2);
        a = {TAG_W'($urandom_range(0, 5)), IDX_W'($urandom), OFF_W'($urandom)};
        apply_stimulus(kind != 1, kind != 0, a, $urandom, $urandom_range(0, 3),
                       om, ow, owa, ord);
      end
    end

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
